// File: rtl/frog_hazard_monitor.sv
// Collects one scan of serialized car/log positions, issues a per-scan hazard verdict and runs the
// frog life FSM. Define FROG_EDGE_DEATH_EN to kill a frog carried past the play-field edge by a log.
module frog_hazard_monitor #(
    parameter int unsigned FROG_SIZE   = 40,
    parameter int unsigned CAR_SIZE    = 40,
    parameter int unsigned LOG_SIZE    = 80,
    parameter int unsigned RIVER_Y_MIN = 40,
    parameter int unsigned RIVER_Y_MAX = 200,
    parameter int unsigned X_MIN       = 39,
    parameter int unsigned X_MAX       = 599,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned DEATH_SCANS = 8,
    parameter int unsigned GRACE_SCANS = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] Frog_X,
    input  logic [9:0] Frog_Y,
    input  logic       Obj_Valid,
    input  logic [9:0] Obj_X,
    input  logic [9:0] Obj_Y,
    input  logic       Obj_IsLog,
    input  logic       Obj_Right,
    input  logic [3:0] Obj_Speed,
    input  logic       Obj_Last,
    input  logic       Frog_Hopping,
    input  logic       Respawn,
    input  logic       New_Game,
    output logic       Death_Pulse,
    output logic [1:0] Death_Cause,
    output logic       Ride_Valid,
    output logic       Ride_Right,
    output logic [3:0] Ride_Speed,
    output logic       Dying,
    output logic       Game_Over,
    output logic [1:0] Lives
);
`ifdef FROG_EDGE_DEATH_EN
    localparam bit EdgeDeathEn = 1'b1;
`else
    localparam bit EdgeDeathEn = 1'b0;
`endif

    localparam logic [10:0] FrogSz    = 11'(FROG_SIZE);
    localparam logic [10:0] CarSz     = 11'(CAR_SIZE);
    localparam logic [10:0] LogSz     = 11'(LOG_SIZE);
    localparam logic [10:0] XMinW     = 11'(X_MIN);
    localparam logic [10:0] XLimW     = 11'(X_MAX + 1);
    localparam logic [9:0]  RiverMin  = 10'(RIVER_Y_MIN);
    localparam logic [9:0]  RiverMax  = 10'(RIVER_Y_MAX);
    localparam int unsigned DcW       = (DEATH_SCANS > 1) ? $clog2(DEATH_SCANS) : 1;
    localparam int unsigned GrW       = (GRACE_SCANS > 0) ? $clog2(GRACE_SCANS + 1) : 1;

    localparam logic [1:0] CauseNone  = 2'd0;
    localparam logic [1:0] CauseCar   = 2'd1;
    localparam logic [1:0] CauseWater = 2'd2;
    localparam logic [1:0] CauseEdge  = 2'd3;

    typedef enum logic [1:0] {StAlive, StDying, StRespawnWait, StGameOver} state_e;

    state_e           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [GrW-1:0]   grace_q, grace_d;
    logic [DcW-1:0]   dying_cnt_q, dying_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             pulse_q, pulse_d;
    logic             ride_valid_q, ride_valid_d;
    logic             ride_right_q, ride_right_d;
    logic [3:0]       ride_speed_q, ride_speed_d;
    logic             hit_car_q, hit_car_d;
    logic             on_log_q, on_log_d;
    logic             log_right_q, log_right_d;
    logic [3:0]       log_speed_q, log_speed_d;

    logic [10:0] frog_x_w, frog_right, obj_x_w, obj_size, obj_left;
    logic        overlap, beat_car, beat_log, verdict;
    logic        scan_car, scan_log, scan_right;
    logic [3:0]  scan_speed;
    logic        in_river, water, edge_hit;
    logic [1:0]  scan_cause;

    // Left edge clamps at 0 so partly off-screen objects never wrap around.
    always_comb begin
        frog_x_w   = {1'b0, Frog_X};
        frog_right = frog_x_w + FrogSz;
        obj_x_w    = {1'b0, Obj_X};
        obj_size   = Obj_IsLog ? LogSz : CarSz;
        obj_left   = (obj_x_w >= obj_size) ? (obj_x_w - obj_size) : 11'd0;
        overlap    = Obj_Valid && (Frog_Y == Obj_Y) && (frog_x_w < obj_x_w) &&
                     (frog_right > obj_left);
        beat_car   = overlap && !Obj_IsLog;
        beat_log   = overlap && Obj_IsLog;
        verdict    = Obj_Valid && Obj_Last;

        scan_car   = hit_car_q || beat_car;
        scan_log   = on_log_q || beat_log;
        scan_right = on_log_q ? log_right_q : Obj_Right;
        scan_speed = on_log_q ? log_speed_q : Obj_Speed;

        in_river   = (Frog_Y >= RiverMin) && (Frog_Y <= RiverMax);
        water      = in_river && !scan_log && !Frog_Hopping;
        edge_hit   = EdgeDeathEn && scan_log && ((frog_x_w < XMinW) || (frog_right > XLimW));

        if (scan_car)      scan_cause = CauseCar;
        else if (edge_hit) scan_cause = CauseEdge;
        else if (water)    scan_cause = CauseWater;
        else               scan_cause = CauseNone;
    end

    always_comb begin
        hit_car_d   = hit_car_q;
        on_log_d    = on_log_q;
        log_right_d = log_right_q;
        log_speed_d = log_speed_q;
        if (verdict) begin
            hit_car_d   = 1'b0;
            on_log_d    = 1'b0;
            log_right_d = 1'b0;
            log_speed_d = 4'd0;
        end else begin
            hit_car_d = scan_car;
            if (beat_log && !on_log_q) begin
                on_log_d    = 1'b1;
                log_right_d = Obj_Right;
                log_speed_d = Obj_Speed;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        grace_d      = grace_q;
        dying_cnt_d  = dying_cnt_q;
        cause_d      = cause_q;
        pulse_d      = 1'b0;
        ride_valid_d = ride_valid_q;
        ride_right_d = ride_right_q;
        ride_speed_d = ride_speed_q;
        unique case (state_q)
            StAlive: begin
                if (verdict) begin
                    if (grace_q != '0) grace_d = grace_q - GrW'(1);
                    if ((scan_cause != CauseNone) && (grace_q == '0)) begin
                        state_d      = StDying;
                        pulse_d      = 1'b1;
                        cause_d      = scan_cause;
                        lives_d      = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        dying_cnt_d  = '0;
                        ride_valid_d = 1'b0;
                        ride_right_d = 1'b0;
                        ride_speed_d = 4'd0;
                    end else begin
                        ride_valid_d = scan_log;
                        ride_right_d = scan_log && scan_right;
                        ride_speed_d = scan_log ? scan_speed : 4'd0;
                    end
                end
            end
            StDying: begin
                if (verdict) begin
                    if (dying_cnt_q == DcW'(DEATH_SCANS - 1)) begin
                        state_d = (lives_q == 2'd0) ? StGameOver : StRespawnWait;
                    end else begin
                        dying_cnt_d = dying_cnt_q + DcW'(1);
                    end
                end
            end
            StRespawnWait: begin
                if (Respawn) begin
                    state_d = StAlive;
                    grace_d = GrW'(GRACE_SCANS);
                end
            end
            StGameOver: begin
                if (New_Game) begin
                    state_d = StAlive;
                    grace_d = GrW'(GRACE_SCANS);
                    lives_d = 2'(LIVES);
                    cause_d = CauseNone;
                end
            end
            default: state_d = StAlive;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StAlive;
            lives_q      <= 2'(LIVES);
            grace_q      <= '0;
            dying_cnt_q  <= '0;
            cause_q      <= CauseNone;
            pulse_q      <= 1'b0;
            ride_valid_q <= 1'b0;
            ride_right_q <= 1'b0;
            ride_speed_q <= 4'd0;
            hit_car_q    <= 1'b0;
            on_log_q     <= 1'b0;
            log_right_q  <= 1'b0;
            log_speed_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            grace_q      <= grace_d;
            dying_cnt_q  <= dying_cnt_d;
            cause_q      <= cause_d;
            pulse_q      <= pulse_d;
            ride_valid_q <= ride_valid_d;
            ride_right_q <= ride_right_d;
            ride_speed_q <= ride_speed_d;
            hit_car_q    <= hit_car_d;
            on_log_q     <= on_log_d;
            log_right_q  <= log_right_d;
            log_speed_q  <= log_speed_d;
        end
    end

    assign Death_Pulse = pulse_q;
    assign Death_Cause = cause_q;
    assign Ride_Valid  = ride_valid_q;
    assign Ride_Right  = ride_right_q;
    assign Ride_Speed  = ride_speed_q;
    assign Dying       = (state_q == StDying);
    assign Game_Over   = (state_q == StGameOver);
    assign Lives       = lives_q;

endmodule

// File: tb/tb_frog_hazard_monitor.sv
// Self-checking bench for frog_hazard_monitor: directed scenarios plus a randomized run checked
// against a queue-based scan model. Honors FROG_EDGE_DEATH_EN when defined.
module tb_frog_hazard_monitor;
    localparam int FROG_SIZE = 40, CAR_SIZE = 40, LOG_SIZE = 80;
    localparam int RIVER_Y_MIN = 40, RIVER_Y_MAX = 200, X_MIN = 39, X_MAX = 599;
    localparam int LIVES = 3, DEATH_SCANS = 8, GRACE_SCANS = 4;
    localparam int MAlive = 0, MDying = 1, MWait = 2, MOver = 3;

    logic       frame_clk, Reset;
    logic [9:0] Frog_X, Frog_Y, Obj_X, Obj_Y;
    logic       Obj_Valid, Obj_IsLog, Obj_Right, Obj_Last, Frog_Hopping, Respawn, New_Game;
    logic [3:0] Obj_Speed;
    logic       Death_Pulse, Ride_Valid, Ride_Right, Dying, Game_Over;
    logic [1:0] Death_Cause, Lives;
    logic [3:0] Ride_Speed;

    int checks, errors;

    frog_hazard_monitor #(
        .FROG_SIZE(FROG_SIZE), .CAR_SIZE(CAR_SIZE), .LOG_SIZE(LOG_SIZE),
        .RIVER_Y_MIN(RIVER_Y_MIN), .RIVER_Y_MAX(RIVER_Y_MAX), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .LIVES(LIVES), .DEATH_SCANS(DEATH_SCANS), .GRACE_SCANS(GRACE_SCANS)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .Frog_X(Frog_X), .Frog_Y(Frog_Y),
        .Obj_Valid(Obj_Valid), .Obj_X(Obj_X), .Obj_Y(Obj_Y), .Obj_IsLog(Obj_IsLog),
        .Obj_Right(Obj_Right), .Obj_Speed(Obj_Speed), .Obj_Last(Obj_Last),
        .Frog_Hopping(Frog_Hopping), .Respawn(Respawn), .New_Game(New_Game),
        .Death_Pulse(Death_Pulse), .Death_Cause(Death_Cause), .Ride_Valid(Ride_Valid),
        .Ride_Right(Ride_Right), .Ride_Speed(Ride_Speed), .Dying(Dying),
        .Game_Over(Game_Over), .Lives(Lives)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Reference model: keep the whole scan as a list, judge it when the last beat lands.
    typedef struct {
        int fx; int fy; int ox; int oy; bit is_log; bit right; int speed;
    } beat_t;
    beat_t beats[$];
    int m_state, m_lives, m_grace, m_left, m_cause, m_rs;
    bit m_pulse, m_rv, m_rr;

    always @(posedge frame_clk or posedge Reset) begin : ref_model
        beat_t b;
        int sz, lo, cause, ls;
        bit car, on_log, lr, edge_hit, water, verdict;
        if (Reset) begin
            beats.delete();
            m_state <= MAlive; m_lives <= LIVES; m_grace <= 0; m_left <= 0; m_cause <= 0;
            m_pulse <= 0; m_rv <= 0; m_rr <= 0; m_rs <= 0;
        end else begin
            verdict = 0; car = 0; on_log = 0; lr = 0; ls = 0; cause = 0;
            if (Obj_Valid) begin
                b.fx = int'(Frog_X); b.fy = int'(Frog_Y); b.ox = int'(Obj_X); b.oy = int'(Obj_Y);
                b.is_log = Obj_IsLog; b.right = Obj_Right; b.speed = int'(Obj_Speed);
                beats.push_back(b);
                if (Obj_Last) begin
                    verdict = 1;
                    foreach (beats[i]) begin
                        sz = beats[i].is_log ? LOG_SIZE : CAR_SIZE;
                        lo = beats[i].ox - sz;
                        if (lo < 0) lo = 0;
                        if (beats[i].fy == beats[i].oy && beats[i].fx < beats[i].ox &&
                            beats[i].fx + FROG_SIZE > lo) begin
                            if (!beats[i].is_log) car = 1;
                            else if (!on_log) begin
                                on_log = 1; lr = beats[i].right; ls = beats[i].speed;
                            end
                        end
                    end
                    beats.delete();
                    water = int'(Frog_Y) >= RIVER_Y_MIN && int'(Frog_Y) <= RIVER_Y_MAX &&
                            !on_log && !Frog_Hopping;
                    edge_hit = 0;
`ifdef FROG_EDGE_DEATH_EN
                    edge_hit = on_log && (int'(Frog_X) < X_MIN ||
                                          int'(Frog_X) + FROG_SIZE > X_MAX + 1);
`endif
                    cause = car ? 1 : edge_hit ? 3 : water ? 2 : 0;
                end
            end
            m_pulse <= 0;
            case (m_state)
                MAlive: if (verdict) begin
                    if (m_grace > 0) m_grace <= m_grace - 1;
                    if (m_grace == 0 && cause != 0) begin
                        m_state <= MDying; m_left <= DEATH_SCANS; m_cause <= cause;
                        m_lives <= (m_lives > 0) ? m_lives - 1 : 0; m_pulse <= 1;
                        m_rv <= 0; m_rr <= 0; m_rs <= 0;
                    end else begin
                        m_rv <= on_log; m_rr <= on_log && lr; m_rs <= on_log ? ls : 0;
                    end
                end
                MDying: if (verdict) begin
                    if (m_left == 1) m_state <= (m_lives == 0) ? MOver : MWait;
                    m_left <= m_left - 1;
                end
                MWait: if (Respawn) begin
                    m_state <= MAlive; m_grace <= GRACE_SCANS;
                end
                default: if (New_Game) begin
                    m_state <= MAlive; m_grace <= GRACE_SCANS; m_lives <= LIVES; m_cause <= 0;
                end
            endcase
        end
    end

    task automatic clear_inputs();
        Obj_Valid = 0; Obj_Last = 0; Obj_IsLog = 0; Obj_Right = 0; Obj_Speed = 0;
        Obj_X = 0; Obj_Y = 0; Respawn = 0; New_Game = 0; Frog_Hopping = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        Frog_X = 10'd200; Frog_Y = 10'd300;
        Reset = 1;
        @(negedge frame_clk); @(negedge frame_clk);
        Reset = 0;
        @(negedge frame_clk);
    endtask

    task automatic beat(input int fx, input int fy, input int ox, input int oy, input bit is_log,
                        input bit right, input int spd, input bit last, input bit hop);
        Frog_X = 10'(fx); Frog_Y = 10'(fy); Obj_X = 10'(ox); Obj_Y = 10'(oy);
        Obj_IsLog = is_log; Obj_Right = right; Obj_Speed = 4'(spd); Obj_Last = last;
        Frog_Hopping = hop; Obj_Valid = 1;
        @(posedge frame_clk); @(negedge frame_clk);
    endtask

    task automatic idle(input bit rsp, input bit ng);
        Obj_Valid = 0; Obj_Last = 0; Respawn = rsp; New_Game = ng;
        @(posedge frame_clk); @(negedge frame_clk);
        Respawn = 0; New_Game = 0;
    endtask

    task automatic empty_scan();
        beat(200, 300, 0, 1023, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (Lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", Lives); end
        checks++; if (Death_Cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", Death_Cause); end
        checks++; if ({Death_Pulse, Dying, Game_Over, Ride_Valid, Ride_Right} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {Death_Pulse, Dying, Game_Over, Ride_Valid, Ride_Right}); end
        checks++; if (Ride_Speed !== 4'd0) begin errors++; $display("FAIL reset_speed: got %0d want 0", Ride_Speed); end
    endtask

    task automatic test_car_hit();
        apply_reset();
        beat(200, 240, 230, 240, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b1) begin errors++; $display("FAIL car_pulse: got %0d want 1", Death_Pulse); end
        checks++; if (Death_Cause !== 2'd1) begin errors++; $display("FAIL car_cause: got %0d want 1", Death_Cause); end
        checks++; if (Lives !== 2'd2) begin errors++; $display("FAIL car_lives: got %0d want 2", Lives); end
        checks++; if (Dying !== 1'b1) begin errors++; $display("FAIL car_dying: got %0d want 1", Dying); end
        idle(0, 0);
        checks++; if (Death_Pulse !== 1'b0) begin errors++; $display("FAIL car_pulse_width: got %0d want 0", Death_Pulse); end
    endtask

    task automatic test_log_ride();
        apply_reset();
        beat(200, 120, 260, 120, 1, 1, 5, 1, 0);
        checks++; if ({Ride_Valid, Ride_Right, Ride_Speed} !== {1'b1, 1'b1, 4'd5}) begin
            errors++; $display("FAIL log_ride: got %b want 1_1_0101", {Ride_Valid, Ride_Right, Ride_Speed}); end
        checks++; if (Death_Pulse !== 1'b0 || Dying !== 1'b0) begin
            errors++; $display("FAIL log_no_death: got pulse=%0d dying=%0d want 0 0", Death_Pulse, Dying); end
        // The first overlapping log of a scan sets the drift.
        beat(200, 120, 250, 120, 1, 0, 3, 0, 0);
        beat(200, 120, 270, 120, 1, 1, 9, 1, 0);
        checks++; if ({Ride_Valid, Ride_Right, Ride_Speed} !== {1'b1, 1'b0, 4'd3}) begin
            errors++; $display("FAIL log_first_latch: got %b want 1_0_0011", {Ride_Valid, Ride_Right, Ride_Speed}); end
    endtask

    task automatic test_water();
        apply_reset();
        beat(200, 120, 500, 120, 1, 0, 2, 1, 0);
        checks++; if (Death_Pulse !== 1'b1 || Death_Cause !== 2'd2) begin
            errors++; $display("FAIL water_death: got pulse=%0d cause=%0d want 1 2", Death_Pulse, Death_Cause); end
        apply_reset();
        beat(200, 120, 500, 120, 1, 0, 2, 1, 1);
        checks++; if (Death_Pulse !== 1'b0 || Dying !== 1'b0) begin
            errors++; $display("FAIL water_hop: got pulse=%0d dying=%0d want 0 0", Death_Pulse, Dying); end
    endtask

    task automatic test_offscreen();
        apply_reset();
        beat(0, 240, 20, 240, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b1 || Death_Cause !== 2'd1) begin
            errors++; $display("FAIL offscreen_hit: got pulse=%0d cause=%0d want 1 1", Death_Pulse, Death_Cause); end
        apply_reset();
        beat(590, 240, 20, 240, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b0 || Dying !== 1'b0) begin
            errors++; $display("FAIL offscreen_wrap: got pulse=%0d dying=%0d want 0 0", Death_Pulse, Dying); end
    endtask

    task automatic test_edge();
        apply_reset();
        beat(570, 120, 620, 120, 1, 1, 2, 1, 0);
`ifdef FROG_EDGE_DEATH_EN
        checks++; if (Death_Pulse !== 1'b1 || Death_Cause !== 2'd3) begin
            errors++; $display("FAIL edge_death: got pulse=%0d cause=%0d want 1 3", Death_Pulse, Death_Cause); end
`else
        checks++; if (Death_Pulse !== 1'b0 || Ride_Valid !== 1'b1) begin
            errors++; $display("FAIL edge_ride: got pulse=%0d ride=%0d want 0 1", Death_Pulse, Ride_Valid); end
`endif
    endtask

    task automatic test_back_to_back();
        apply_reset();
        beat(200, 120, 260, 120, 1, 1, 5, 1, 0);
        checks++; if (Ride_Valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %0d want 1", Ride_Valid); end
        beat(200, 120, 0, 1023, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b1 || Death_Cause !== 2'd2 || Ride_Valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got pulse=%0d cause=%0d ride=%0d want 1 2 0", Death_Pulse, Death_Cause, Ride_Valid); end
        apply_reset();
        beat(200, 240, 230, 240, 0, 0, 0, 0, 0);
        beat(200, 240, 0, 1023, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b1 || Death_Cause !== 2'd1) begin
            errors++; $display("FAIL accum_car: got pulse=%0d cause=%0d want 1 1", Death_Pulse, Death_Cause); end
    endtask

    task automatic test_reset_midscan();
        apply_reset();
        beat(200, 240, 230, 240, 0, 0, 0, 0, 0);
        apply_reset();
        beat(200, 240, 0, 1023, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b0 || Lives !== 2'd3) begin
            errors++; $display("FAIL midscan_reset: got pulse=%0d lives=%0d want 0 3", Death_Pulse, Lives); end
    endtask

    task automatic test_game_over();
        apply_reset();
        for (int life = 0; life < 3; life++) begin
            if (life > 0) begin
                for (int g = 0; g < GRACE_SCANS; g++) begin
                    beat(200, 240, 230, 240, 0, 0, 0, 1, 0);
                    checks++; if (Death_Pulse !== 1'b0) begin errors++; $display("FAIL grace_respawn: got %0d want 0", Death_Pulse); end
                end
            end
            beat(200, 240, 230, 240, 0, 0, 0, 1, 0);
            checks++; if (Death_Pulse !== 1'b1 || Lives !== 2'(2 - life)) begin
                errors++; $display("FAIL life_death: got pulse=%0d lives=%0d want 1 %0d", Death_Pulse, Lives, 2 - life); end
            for (int s = 0; s < DEATH_SCANS; s++) begin
                empty_scan();
                if (s < DEATH_SCANS - 1) begin
                    checks++; if (Dying !== 1'b1) begin errors++; $display("FAIL dying_hold: got %0d want 1", Dying); end
                end
            end
            if (life < 2) begin
                checks++; if (Dying !== 1'b0 || Game_Over !== 1'b0) begin
                    errors++; $display("FAIL respawn_wait: got dying=%0d go=%0d want 0 0", Dying, Game_Over); end
                idle(1, 0);
            end
        end
        checks++; if (Game_Over !== 1'b1 || Lives !== 2'd0) begin
            errors++; $display("FAIL game_over: got go=%0d lives=%0d want 1 0", Game_Over, Lives); end
        idle(1, 0);
        checks++; if (Game_Over !== 1'b1) begin errors++; $display("FAIL respawn_ignored: got %0d want 1", Game_Over); end
        idle(0, 1);
        checks++; if (Game_Over !== 1'b0 || Lives !== 2'd3 || Death_Cause !== 2'd0) begin
            errors++; $display("FAIL new_game: got go=%0d lives=%0d cause=%0d want 0 3 0", Game_Over, Lives, Death_Cause); end
        for (int g = 0; g < GRACE_SCANS; g++) begin
            beat(200, 240, 230, 240, 0, 0, 0, 1, 0);
            checks++; if (Death_Pulse !== 1'b0) begin errors++; $display("FAIL grace_new_game: got %0d want 0", Death_Pulse); end
        end
        beat(200, 240, 230, 240, 0, 0, 0, 1, 0);
        checks++; if (Death_Pulse !== 1'b1 || Lives !== 2'd2) begin
            errors++; $display("FAIL grace_expired: got pulse=%0d lives=%0d want 1 2", Death_Pulse, Lives); end
    endtask

    task automatic test_random();
        int lanes[4] = '{120, 160, 240, 40};
        int fx, ox;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            fx = int'($urandom_range(0, 600));
            ox = fx + int'($urandom_range(0, 160)) - 20;
            if (ox < 0) ox = 0;
            Frog_X = 10'(fx);
            Frog_Y = 10'(lanes[$urandom_range(0, 3)]);
            Obj_X = 10'(ox);
            Obj_Y = 10'(lanes[$urandom_range(0, 3)]);
            Obj_Valid = ($urandom_range(0, 3) != 0);
            Obj_Last = ($urandom_range(0, 2) == 0);
            Obj_IsLog = $urandom_range(0, 1) != 0;
            Obj_Right = $urandom_range(0, 1) != 0;
            Obj_Speed = 4'($urandom_range(0, 15));
            Frog_Hopping = ($urandom_range(0, 3) == 0);
            Respawn = ($urandom_range(0, 7) == 0);
            New_Game = ($urandom_range(0, 7) == 0);
            @(posedge frame_clk); @(negedge frame_clk);
            checks++; if (Death_Pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d: got %0d want %0d", c, Death_Pulse, m_pulse); end
            checks++; if (Death_Cause !== 2'(m_cause)) begin errors++; $display("FAIL rnd_cause cyc %0d: got %0d want %0d", c, Death_Cause, m_cause); end
            checks++; if (Lives !== 2'(m_lives)) begin errors++; $display("FAIL rnd_lives cyc %0d: got %0d want %0d", c, Lives, m_lives); end
            checks++; if (Dying !== (m_state == MDying)) begin errors++; $display("FAIL rnd_dying cyc %0d: got %0d want %0d", c, Dying, m_state == MDying); end
            checks++; if (Game_Over !== (m_state == MOver)) begin errors++; $display("FAIL rnd_over cyc %0d: got %0d want %0d", c, Game_Over, m_state == MOver); end
            checks++; if ({Ride_Valid, Ride_Right, Ride_Speed} !== {m_rv, m_rr, 4'(m_rs)}) begin
                errors++; $display("FAIL rnd_ride cyc %0d: got %b want %b", c, {Ride_Valid, Ride_Right, Ride_Speed}, {m_rv, m_rr, 4'(m_rs)}); end
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        Reset = 1; Frog_X = 0; Frog_Y = 0;
        clear_inputs();
        test_reset();
        test_car_hit();
        test_log_ride();
        test_water();
        test_offscreen();
        test_edge();
        test_back_to_back();
        test_reset_midscan();
        test_game_over();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frog_hazard_monitor.md
Name: frog_hazard_monitor

Overview:
- Consumer side of the car/log position interface; movers' X/Y positions are serialized into this block one object per frame_clk beat.
- Compares each object against the frog box and, per scan, produces a verdict: squashed by a car, drowned in the river, or riding a log (with drift direction and speed for the frog controller).
- Owns frog life state (alive/dying/respawn/game over), a lives counter, and post-respawn grace.

Parameters:
- FROG_SIZE, 40, frog box width in px.
- CAR_SIZE, 40, car length in px.
- LOG_SIZE, 80, log length in px.
- RIVER_Y_MIN, 40, first river lane Y (inclusive).
- RIVER_Y_MAX, 200, last river lane Y (inclusive).
- X_MIN, 39, play-field left bound.
- X_MAX, 599, play-field right bound.
- LIVES, 3, lives at reset/new game (1..3).
- DEATH_SCANS, 8, scans spent in DYING.
- GRACE_SCANS, 4, scans after respawn with hazards ignored.

Ports:
- frame_clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Frog_X, Frog_Y  in  10 each  frog top-left position; sampled on every valid beat.
- Obj_Valid  in  1  object beat valid.
- Obj_X, Obj_Y  in  10 each  object position; object spans [Obj_X-size, Obj_X-1], lane Y = Obj_Y.
- Obj_IsLog  in  1  1=log (LOG_SIZE), 0=car (CAR_SIZE).
- Obj_Right  in  1  object direction.
- Obj_Speed  in  4  object speed code.
- Obj_Last  in  1  last beat of scan; qualified by Obj_Valid.
- Frog_Hopping  in  1  frog mid-hop; suppresses drown check only.
- Respawn  in  1  leave RESPAWN_WAIT.
- New_Game  in  1  leave GAME_OVER.
- Death_Pulse  out  1  one-cycle pulse on death.
- Death_Cause  out  2  0 none, 1 car, 2 water, 3 edge; held until next death or reset.
- Ride_Valid, Ride_Right  out  1 each  frog on a log and that log's direction.
- Ride_Speed  out  4  riding log speed.
- Dying, Game_Over  out  1 each  state flags.
- Lives  out  2  remaining lives.

Behaviour:
- Reset: state ALIVE, Lives=LIVES, grace=0, accumulators clear, all other outputs 0.
- Overlap uses 11-bit unsigned math: Frog_Y==Obj_Y && Frog_X < Obj_X && Frog_X+FROG_SIZE > Obj_X-size.
- Obj_X < size is legal (object partly off-screen): the left edge clamps to 0, with no underflow.
- On each valid beat, OR into the accumulators: hit_car (car overlap) and on_log (log overlap; the first overlapping log latches direction/speed).
- Verdict is registered 1 cycle after the Obj_Last beat. The Obj_Last beat's object is included. Accumulators clear in that same cycle.
- A valid beat arriving in the verdict cycle starts the next scan.
- Hazard priority: car > water > none.
  - water = frog in river band && !on_log && !Frog_Hopping.
- Ride_Valid/Ride_Right/Ride_Speed update at each verdict in ALIVE (Ride_Valid=on_log). They are forced to 0 outside ALIVE.
- Grace: set to GRACE_SCANS on entering ALIVE from RESPAWN_WAIT/GAME_OVER; decrements per verdict; hazards ignored while nonzero.
- FSM:
  - ALIVE: hazard && grace==0 at verdict → DYING. Assert Death_Pulse, latch Death_Cause, Lives-1 (saturate at 0).
  - DYING: Dying=1; count DEATH_SCANS verdicts, then → GAME_OVER if Lives==0, else → RESPAWN_WAIT.
  - RESPAWN_WAIT: Respawn → ALIVE.
  - GAME_OVER: Game_Over=1; New_Game → ALIVE with Lives=LIVES, Death_Cause=0.
- Respawn/New_Game have no effect in other states. Reset mid-scan discards partial accumulators.

Optional Feature:
- FROG_EDGE_DEATH_EN defined: in ALIVE at a verdict with on_log, the frog dies with cause 3 if Frog_X < X_MIN or Frog_X+FROG_SIZE > X_MAX+1. Priority is below car and above water.
- Undefined: no edge check; cause code 3 is never produced.

Test Plan:
- Frog (200,240), scan of one car Obj_X=230,Y=240 Last=1 → Death_Pulse 1 cycle after, Death_Cause=1, Lives 3→2, Dying=1.
- Frog (200,120) in river, log Obj_X=260,Y=120,Right=1,Speed=5 → Ride_Valid=1, Ride_Right=1, Ride_Speed=5, no death.
- Frog (200,120), log Obj_X=500 only → Death_Cause=2; repeat with Frog_Hopping=1 → no death.
- Three deaths, then 8 scans → Game_Over=1, Lives=0; Respawn ignored; New_Game → ALIVE, Lives=3; car hit in the next 4 scans ignored, 5th kills.
- Car Obj_X=20 (partly off-screen), frog X=0 same lane → car death, no wrap false-hit at X=590.
- With FROG_EDGE_DEATH_EN: frog X=570 on log → Death_Cause=3; without it → Ride_Valid=1, no death.
